// File: rtl/station_credit_tracker.sv
// Station and ROB credit tracker: keeps free-entry counts for every
// reservation station and the reorder buffer, and drives the registered
// full flags that the issuer reads before issuing an instruction pair.
module station_credit_tracker #(
   parameter int unsigned AL_DEPTH    = 8,
   parameter int unsigned BR_DEPTH    = 4,
   parameter int unsigned LS_DEPTH    = 8,
   parameter int unsigned MD_DEPTH    = 4,
   parameter int unsigned RB_DEPTH    = 16,
   parameter int unsigned FULL_THRESH = 2,
   parameter int unsigned CNT_W       = $clog2(RB_DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic [1:0]       issue_valid,
   input  logic [2:0]       issue_type_0,
   input  logic [2:0]       issue_type_1,
   input  logic             rel_alu,
   input  logic             rel_branch,
   input  logic             rel_load_store,
   input  logic             rel_mult_div,
   input  logic [1:0]       rob_retire,
   output logic             full_alu,
   output logic             full_branch,
   output logic             full_load_store,
   output logic             full_mult_div,
   output logic             full_rob,
   output logic [CNT_W-1:0] free_rob,
   output logic             credit_err
);

   localparam int unsigned NUM_CNT = 5;
   localparam int unsigned NW      = CNT_W + 1;

   // Counter slots
   localparam int unsigned IX_AL = 0;
   localparam int unsigned IX_BR = 1;
   localparam int unsigned IX_LS = 2;
   localparam int unsigned IX_MD = 3;
   localparam int unsigned IX_RB = 4;

   // Issue type encoding
   localparam logic [2:0] TY_AL = 3'd0;
   localparam logic [2:0] TY_BR = 3'd1;
   localparam logic [2:0] TY_LS = 3'd2;
   localparam logic [2:0] TY_RB = 3'd3;
   localparam logic [2:0] TY_MD = 3'd4;

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t DEPTH_TAB [NUM_CNT] = '{
      cnt_t'(AL_DEPTH), cnt_t'(BR_DEPTH), cnt_t'(LS_DEPTH),
      cnt_t'(MD_DEPTH), cnt_t'(RB_DEPTH)
   };
   localparam cnt_t THRESH = cnt_t'(FULL_THRESH);

   cnt_t                  free_q  [NUM_CNT];
   cnt_t                  free_d  [NUM_CNT];
   logic [NUM_CNT-1:0]    full_q;
   logic [NUM_CNT-1:0]    full_d;
   logic                  err_q;
   logic                  err_d;

   logic [2:0]            slot_type [2];
   logic [1:0]            dec_c   [NUM_CNT];
   logic [1:0]            inc_c   [NUM_CNT];
   logic signed [NW-1:0]  raw_c   [NUM_CNT];
   cnt_t                  sat_c   [NUM_CNT];
   logic [NUM_CNT-1:0]    sat_err_c;
   logic                  type_err_c;
   logic                  retire_err_c;

   assign slot_type[0] = issue_type_0;
   assign slot_type[1] = issue_type_1;

   // Debits: each valid slot takes one ROB entry plus one entry of its station
   always_comb begin
      for (int i = 0; i < int'(NUM_CNT); i++) dec_c[i] = 2'd0;
      type_err_c = 1'b0;
      for (int s = 0; s < 2; s++) begin
         if (issue_valid[s]) begin
            dec_c[IX_RB] = dec_c[IX_RB] + 2'd1;
            case (slot_type[s])
               TY_AL:   dec_c[IX_AL] = dec_c[IX_AL] + 2'd1;
               TY_BR:   dec_c[IX_BR] = dec_c[IX_BR] + 2'd1;
               TY_LS:   dec_c[IX_LS] = dec_c[IX_LS] + 2'd1;
               TY_MD:   dec_c[IX_MD] = dec_c[IX_MD] + 2'd1;
               TY_RB:   ;
               default: type_err_c = 1'b1;
            endcase
         end
      end
   end

   // Credits: station releases and ROB retirement (3 is clamped to 2)
   always_comb begin
      inc_c[IX_AL] = {1'b0, rel_alu};
      inc_c[IX_BR] = {1'b0, rel_branch};
      inc_c[IX_LS] = {1'b0, rel_load_store};
      inc_c[IX_MD] = {1'b0, rel_mult_div};
      inc_c[IX_RB] = (rob_retire == 2'd3) ? 2'd2 : rob_retire;
      retire_err_c = &rob_retire;
   end

   // Signed next count, clamped to [0, DEPTH]; any clamp is a credit error
   always_comb begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
         raw_c[i]     = $signed({1'b0, free_q[i]}) - $signed(NW'(dec_c[i]))
                        + $signed(NW'(inc_c[i]));
         sat_c[i]     = raw_c[i][CNT_W-1:0];
         sat_err_c[i] = 1'b0;
         if (raw_c[i][NW-1]) begin
            sat_c[i]     = '0;
            sat_err_c[i] = 1'b1;
         end else if (raw_c[i] > $signed({1'b0, DEPTH_TAB[i]})) begin
            sat_c[i]     = DEPTH_TAB[i];
            sat_err_c[i] = 1'b1;
         end
      end
   end

   // Next state: flush restores every counter and ignores this cycle's traffic
   always_comb begin
      for (int i = 0; i < int'(NUM_CNT); i++) begin
         free_d[i] = flush ? DEPTH_TAB[i] : sat_c[i];
         full_d[i] = !flush && (sat_c[i] < THRESH);
      end
      err_d = err_q | (!flush & ((|sat_err_c) | type_err_c | retire_err_c));
   end

   // Counter, flag and sticky error registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_CNT); i++) free_q[i] <= DEPTH_TAB[i];
         full_q <= '0;
         err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_CNT); i++) free_q[i] <= free_d[i];
         full_q <= full_d;
         err_q  <= err_d;
      end
   end

   assign full_alu        = full_q[IX_AL];
   assign full_branch     = full_q[IX_BR];
   assign full_load_store = full_q[IX_LS];
   assign full_mult_div   = full_q[IX_MD];
   assign full_rob        = full_q[IX_RB];
   assign free_rob        = free_q[IX_RB];
   assign credit_err      = err_q;

endmodule

// File: tb/tb_station_credit_tracker.sv
// Directed bench for station_credit_tracker with hand-computed expectations.
module tb_station_credit_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic       flush;
   logic [1:0] issue_valid;
   logic [2:0] issue_type_0;
   logic [2:0] issue_type_1;
   logic       rel_alu;
   logic       rel_branch;
   logic       rel_load_store;
   logic       rel_mult_div;
   logic [1:0] rob_retire;
   logic       full_alu;
   logic       full_branch;
   logic       full_load_store;
   logic       full_mult_div;
   logic       full_rob;
   logic [4:0] free_rob;
   logic       credit_err;

   int errors = 0;
   int checks = 0;

   station_credit_tracker dut (
      .clock           (clk),
      .reset           (reset),
      .flush           (flush),
      .issue_valid     (issue_valid),
      .issue_type_0    (issue_type_0),
      .issue_type_1    (issue_type_1),
      .rel_alu         (rel_alu),
      .rel_branch      (rel_branch),
      .rel_load_store  (rel_load_store),
      .rel_mult_div    (rel_mult_div),
      .rob_retire      (rob_retire),
      .full_alu        (full_alu),
      .full_branch     (full_branch),
      .full_load_store (full_load_store),
      .full_mult_div   (full_mult_div),
      .full_rob        (full_rob),
      .free_rob        (free_rob),
      .credit_err      (credit_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Check every output at once: fulls as {alu,br,ls,md,rob}
   task automatic check_all(input string tag, input logic [4:0] fulls,
                            input int rob, input logic err);
      check({tag, ".full"}, int'({full_alu, full_branch, full_load_store,
                                  full_mult_div, full_rob}), int'(fulls));
      check({tag, ".free_rob"}, int'(free_rob), rob);
      check({tag, ".err"}, int'(credit_err), int'(err));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0; issue_valid = 2'b00; issue_type_0 = 3'd0; issue_type_1 = 3'd0;
      rel_alu = 1'b0; rel_branch = 1'b0; rel_load_store = 1'b0;
      rel_mult_div = 1'b0; rob_retire = 2'd0;
   endtask

   task automatic issue(input logic [1:0] v, input logic [2:0] t0, input logic [2:0] t1);
      issue_valid = v; issue_type_0 = t0; issue_type_1 = t1;
   endtask

   // Asynchronous reset pulse away from clock edges
   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1 check_all("rst_async", 5'b00000, 16, 1'b0);
      #2 reset = 1'b1;
      idle();
      tick();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      tick();
      check_all("in_reset", 5'b00000, 16, 1'b0);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         check_all("idle", 5'b00000, 16, 1'b0);
      end

      // ALU pairs: 8 -> 6 -> 4 -> 2 -> 0
      issue(2'b11, 3'd0, 3'd0);
      tick(); tick(); tick();
      check_all("alu_at2", 5'b00000, 10, 1'b0);
      tick();
      check_all("alu_at0", 5'b10000, 8, 1'b0);
      idle(); rel_alu = 1'b1;
      tick();
      check_all("alu_at1", 5'b10000, 8, 1'b0);
      issue(2'b01, 3'd0, 3'd0); rel_alu = 1'b1;
      tick();
      check_all("alu_net", 5'b10000, 7, 1'b0);
      idle(); rel_alu = 1'b1;
      tick();
      check_all("alu_at2b", 5'b00000, 7, 1'b0);

      // Branch over-issue saturates and sets the sticky error
      idle(); issue(2'b11, 3'd1, 3'd1);
      tick();
      check_all("br_at2", 5'b00000, 5, 1'b0);
      tick();
      check_all("br_at0", 5'b01000, 3, 1'b0);
      issue(2'b10, 3'd0, 3'd1);
      tick();
      check_all("br_under", 5'b01000, 2, 1'b1);
      idle();
      tick();
      check_all("err_sticky", 5'b01000, 2, 1'b1);
      flush = 1'b1;
      tick();
      check_all("flush_br", 5'b00000, 16, 1'b1);

      // ROB over-retire from full
      idle();
      pulse_reset();
      check_all("post_rst", 5'b00000, 16, 1'b0);
      rob_retire = 2'd2;
      tick();
      check_all("rob_over", 5'b00000, 16, 1'b1);

      // rob_retire = 3 acts as 2; RB type touches only the ROB
      idle();
      pulse_reset();
      issue(2'b11, 3'd3, 3'd3);
      tick(); tick();
      check_all("rb_only", 5'b00000, 12, 1'b0);
      idle(); rob_retire = 2'd3;
      tick();
      check_all("retire3", 5'b00000, 14, 1'b1);

      // Illegal type debits ROB only; invalid slot types are ignored
      idle();
      pulse_reset();
      issue(2'b00, 3'd7, 3'd6);
      tick();
      check_all("inv_type", 5'b00000, 16, 1'b0);
      issue(2'b01, 3'd5, 3'd7);
      tick();
      check_all("bad_type", 5'b00000, 15, 1'b1);

      // Flush overrides same-cycle issue and release
      idle();
      pulse_reset();
      issue(2'b11, 3'd4, 3'd4);
      tick(); tick();
      check_all("md_at0", 5'b00010, 12, 1'b0);
      issue(2'b11, 3'd2, 3'd2);
      tick(); tick(); tick();
      check_all("ls_at2", 5'b00010, 6, 1'b0);
      issue(2'b11, 3'd2, 3'd4); rel_load_store = 1'b1; flush = 1'b1;
      tick();
      check_all("flush_tr", 5'b00000, 16, 1'b0);
      idle(); issue(2'b11, 3'd4, 3'd4);
      tick();
      check_all("md_re2", 5'b00000, 14, 1'b0);
      tick();
      check_all("md_re0", 5'b00010, 12, 1'b0);

      // Mid-traffic reset, then first edge after release updates
      issue(2'b11, 3'd0, 3'd3);
      pulse_reset();
      check_all("rst_first", 5'b00000, 16, 1'b0);
      issue(2'b11, 3'd0, 3'd0);
      tick();
      check_all("after_rst", 5'b00000, 14, 1'b0);

      // ROB threshold boundary
      idle();
      pulse_reset();
      issue(2'b11, 3'd3, 3'd3);
      for (int c = 0; c < 7; c++) tick();
      check_all("rob_at2", 5'b00000, 2, 1'b0);
      issue(2'b01, 3'd3, 3'd0);
      tick();
      check_all("rob_at1", 5'b00001, 1, 1'b0);
      idle(); rob_retire = 2'd2;
      tick();
      check_all("rob_at3", 5'b00000, 3, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/station_credit_tracker.md
Name: station_credit_tracker

Overview:
Tracks free entries in every destination station (ALU, branch, load/store, mult/div) and in the reorder buffer, and drives the per-resource full flags the issuer reads before issuing a pair of instructions. Counts are debited on every issued instruction and credited on every station dispatch or ROB retirement. Sits between the issuer and the back end, and provides the source of the fullness bus.

Parameters:
AL_DEPTH, 8, ALU reservation station entries
BR_DEPTH, 4, branch station entries
LS_DEPTH, 8, load/store station entries
MD_DEPTH, 4, mult/div station entries
RB_DEPTH, 16, reorder buffer entries
FULL_THRESH, 2, full asserted when free count < FULL_THRESH; must be >= 2 (issue width)
CNT_W, $clog2(RB_DEPTH+1), counter width; must hold every DEPTH value

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; all state to reset values while low
flush  in  1  pipeline flush; restores every counter to its DEPTH
issue_valid  in  2  bit i = instruction slot i issued this cycle
issue_type_0  in  3  type of slot 0: AL=0, BR=1, LS=2, RB=3, MD=4
issue_type_1  in  3  type of slot 1, same encoding
rel_alu  in  1  ALU station freed one entry
rel_branch  in  1  branch station freed one entry
rel_load_store  in  1  load/store station freed one entry
rel_mult_div  in  1  mult/div station freed one entry
rob_retire  in  2  ROB entries retired this cycle, 0..2 (3 illegal)
full_alu  out  1  registered, free_alu < FULL_THRESH
full_branch  out  1  registered
full_load_store  out  1  registered
full_mult_div  out  1  registered
full_rob  out  1  registered
free_rob  out  CNT_W  registered ROB free count, for debug and perf counters
credit_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset low, asynchronous): free_X = X_DEPTH for all five counters. All full_* = 0. free_rob = RB_DEPTH. credit_err = 0.
- Per cycle and per station X: dec_X = number of valid slots with type X (0..2); inc_X = rel_X (0..1).
- ROB: every valid slot, of any type, debits one ROB entry, so dec_RB = popcount(issue_valid). Type RB occupies the ROB only. inc_RB = rob_retire.
- next_X = free_X - dec_X + inc_X, computed at CNT_W+1 bits signed. Issue and release in the same cycle net out.
- Saturation: next < 0 sets the counter to 0 and credit_err to 1. next > X_DEPTH sets the counter to X_DEPTH and credit_err to 1.
- Illegal inputs also set credit_err to 1:
  - issue type > 4: the slot debits the ROB only.
  - rob_retire == 3: treated as 2.
- Full flags are registered from next values: full_X <= (next_X_saturated < FULL_THRESH). A flag reflects the issues and releases of cycle N in cycle N+1, with one-cycle latency. FULL_THRESH=2 guarantees that a same-type pair issued on a deasserted flag always fits.
- flush (synchronous, sampled on the edge): all counters go to DEPTH and all full_* go to 0. Issue and release in the same cycle are ignored. credit_err is not cleared; only reset clears it.
- issue_valid low: type inputs are don't-care, with no debit and no error check.
- Reset asserted mid-operation: immediate return to reset values. First update on the first rising edge after release.
- Combinational outputs: none; every output comes straight from a flop.

Test Plan:
- Reset release, no traffic -> full_* = 0, free_rob = 16, credit_err = 0, held for 10 cycles.
- Issue AL+AL for 3 cycles (free_alu 8->2), then AL+AL in the 4th cycle -> free_alu = 0 and full_alu = 1 on the following cycle. free_rob = 8, full_rob = 0.
- With free_alu = 1: issue one AL plus rel_alu in the same cycle -> free_alu stays 1 and full_alu stays 1. Add rel_alu alone -> free_alu = 2 and full_alu = 0 the next cycle.
- Issue a pair of BR instructions with BR_DEPTH = 4 twice, then one more BR -> count saturates at 0 and credit_err = 1 (sticky). A flush then restores free_branch = 4 and clears full_branch, while credit_err stays 1.
- rob_retire = 2 while free_rob = 16 -> free_rob stays 16 and credit_err = 1. rob_retire = 3 -> treated as 2, credit_err = 1.
- Flush asserted in the same cycle as issue of LS+MD and rel_load_store -> every free count equals its DEPTH next cycle, all full_* = 0. Reset pulsed mid-traffic -> outputs return to reset values asynchronously, before any clock edge.
